match_resp_reorder: RTL

Multi-group successor to the single-group match response synchroniser in the match engine. It tracks up to D outstanding lazy-match request groups. It collects per-position match lengths from C match_pe response channels, which may return in any order across groups. Completed groups are released to job_pe strictly in allocation order.

---
 rtl/match_resp_reorder_pkg.sv | 22 ++
 rtl/match_resp_slot.sv | 68 ++++++
 rtl/match_resp_reorder.sv | 118 +++++++++++
 3 files changed

// File: rtl/match_resp_reorder_pkg.sv
// Shared defaults, slot record and pointer-width helper for the match response
// reorder buffer.
package match_resp_reorder_pkg;

  localparam int LAZY_LEN         = 4;
  localparam int NUM_MATCH_REQ_CH = 2;
  localparam int LAZY_LEN_LOG2    = 2;
  localparam int MATCH_LEN_WIDTH  = 8;
  localparam int NUM_GROUP_SLOTS  = 4;

  typedef struct packed {
    logic                                  alloc;
    logic [LAZY_LEN-1:0]                   strb;
    logic [LAZY_LEN-1:0]                   done;
    logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0]   len;
  } slot_rec_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/match_resp_slot.sv
// One group slot: allocation, per-position response merge with lowest-channel
// priority, and duplicate detection against already-done positions.
module match_resp_slot
  import match_resp_reorder_pkg::*;
#(
  parameter int C        = NUM_MATCH_REQ_CH,
  parameter int TAG_BITS = LAZY_LEN_LOG2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_en_i,
  input  logic [LAZY_LEN-1:0]             alloc_strb_i,
  input  logic                            pop_en_i,
  input  logic [C-1:0]                    wr_en_i,
  input  logic [C*TAG_BITS-1:0]           wr_tag_i,
  input  logic [C*MATCH_LEN_WIDTH-1:0]    wr_len_i,
  output slot_rec_t                       rec_o,
  output logic                            complete_o,
  output logic                            dup_o
);

  localparam int L  = LAZY_LEN;
  localparam int ML = MATCH_LEN_WIDTH;

  slot_rec_t      rec_q, rec_d;
  logic [L-1:0]   taken;

  always_comb begin
    rec_d = rec_q;
    taken = '0;
    dup_o = 1'b0;
    // Channels are scanned in index order, so the lowest channel claims a position first.
    for (int c = 0; c < C; c++) begin
      for (int p = 0; p < L; p++) begin
        if (wr_en_i[c] && (wr_tag_i[c*TAG_BITS +: TAG_BITS] == TAG_BITS'(p))) begin
          if (rec_q.done[p] || taken[p]) begin
            dup_o = 1'b1;
          end else begin
            taken[p]              = 1'b1;
            rec_d.done[p]         = 1'b1;
            rec_d.len[p*ML +: ML] = wr_len_i[c*ML +: ML];
          end
        end
      end
    end
    if (pop_en_i) begin
      rec_d = '0;
    end
    if (alloc_en_i) begin
      rec_d.alloc = 1'b1;
      rec_d.strb  = alloc_strb_i;
      rec_d.done  = ~alloc_strb_i;
      rec_d.len   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_o      = rec_q;
  assign complete_o = rec_q.alloc & (&rec_q.done);

endmodule

// File: rtl/match_resp_reorder.sv
// Multi-group match response reorder buffer: collects out-of-order per-position
// responses into D slots and releases complete groups in allocation order.
module match_resp_reorder
  import match_resp_reorder_pkg::*;
#(
  parameter int L        = LAZY_LEN,
  parameter int C        = NUM_MATCH_REQ_CH,
  parameter int TAG_BITS = LAZY_LEN_LOG2,
  parameter int ML       = MATCH_LEN_WIDTH,
  parameter int D        = NUM_GROUP_SLOTS,
  parameter int GID_BITS = ptr_width(D)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_group_valid,
  output logic                     req_group_ready,
  input  logic [L-1:0]             req_group_strb,
  output logic [GID_BITS-1:0]      req_group_gid,
  input  logic [C-1:0]             resp_valid,
  output logic [C-1:0]             resp_ready,
  input  logic [C*GID_BITS-1:0]    resp_gid,
  input  logic [C*TAG_BITS-1:0]    resp_tag,
  input  logic [C*ML-1:0]          resp_match_len,
  output logic                     resp_group_valid,
  input  logic                     resp_group_ready,
  output logic [L*ML-1:0]          resp_group_match_len,
  output logic [L-1:0]             resp_group_strb,
  output logic [GID_BITS:0]        occupancy,
  output logic                     err_dup
);

  localparam logic [TAG_BITS:0]  TAG_LIMIT = (TAG_BITS+1)'(L);
  localparam logic [GID_BITS:0]  FULL_CNT  = (GID_BITS+1)'(D);

  logic [GID_BITS-1:0]  head_q, head_d, tail_q, tail_d;
  logic [GID_BITS:0]    count_q, count_d;
  logic                 err_q, err_d;

  slot_rec_t            slot_rec [D];
  logic [D-1:0]         slot_alloc, slot_complete, slot_dup;
  logic [C-1:0]         slot_wr [D];
  logic [C-1:0]         resp_acc, tag_ok;
  logic                 do_alloc, do_pop;

  always_comb begin
    resp_ready = '0;
    tag_ok     = '0;
    for (int j = 0; j < C; j++) begin
      resp_ready[j] = slot_alloc[resp_gid[j*GID_BITS +: GID_BITS]];
      tag_ok[j]     = {1'b0, resp_tag[j*TAG_BITS +: TAG_BITS]} < TAG_LIMIT;
    end
    resp_acc = resp_valid & resp_ready;
    // Out-of-range tags are accepted but never routed to a slot.
    for (int s = 0; s < D; s++) begin
      for (int j = 0; j < C; j++) begin
        slot_wr[s][j] = resp_acc[j] & tag_ok[j] &
                        (resp_gid[j*GID_BITS +: GID_BITS] == GID_BITS'(s));
      end
    end
  end

  assign req_group_ready      = (count_q != FULL_CNT);
  assign req_group_gid        = tail_q;
  assign do_alloc             = req_group_valid & req_group_ready;
  assign resp_group_valid     = slot_complete[head_q];
  assign do_pop               = resp_group_valid & resp_group_ready;
  assign resp_group_match_len = slot_rec[head_q].len;
  assign resp_group_strb      = slot_rec[head_q].strb;
  assign occupancy            = count_q;
  assign err_dup              = err_q;

  always_comb begin
    head_d  = do_pop   ? head_q + 1'b1 : head_q;
    tail_d  = do_alloc ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (do_alloc && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_alloc && do_pop) begin
      count_d = count_q - 1'b1;
    end
    err_d = err_q | (|(resp_acc & ~tag_ok)) | (|slot_dup);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  for (genvar s = 0; s < D; s++) begin : g_slot
    match_resp_slot #(
      .C        (C),
      .TAG_BITS (TAG_BITS)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_en_i   (do_alloc && (tail_q == GID_BITS'(s))),
      .alloc_strb_i (req_group_strb),
      .pop_en_i     (do_pop && (head_q == GID_BITS'(s))),
      .wr_en_i      (slot_wr[s]),
      .wr_tag_i     (resp_tag),
      .wr_len_i     (resp_match_len),
      .rec_o        (slot_rec[s]),
      .complete_o   (slot_complete[s]),
      .dup_o        (slot_dup[s])
    );
    assign slot_alloc[s] = slot_rec[s].alloc;
  end

endmodule
